// File: rtl/writeback_stage.sv
// W-stage pipeline register and regfile write-port driver with cmov squash, stall/bubble and halt tracking.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m_valid,
  input  logic [2:0]        m_stat,
  input  logic [3:0]        m_icode,
  input  logic              m_cnd,
  input  logic [3:0]        m_dstE,
  input  logic [DATA_W-1:0] m_valE,
  input  logic [3:0]        m_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic              w_stall,
  input  logic              w_bubble,
  output logic [3:0]        dstE,
  output logic [DATA_W-1:0] valE,
  output logic [3:0]        dstM,
  output logic [DATA_W-1:0] valM,
  output logic [2:0]        w_stat,
  output logic              halted,
  output logic [2:0]        halt_code,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam logic [2:0] S_BUB = 3'd0, S_AOK = 3'd1, S_HLT = 3'd2, S_ADR = 3'd3, S_INS = 3'd4;
  localparam logic [3:0] R_NONE = 4'hF, I_CMOV = 4'h2;

  typedef enum logic {RUN, HALT} state_t;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_stat, r_halt_code;
  logic [3:0]         r_dstE, r_dstM;
  logic [DATA_W-1:0]  r_valE, r_valM;
  logic               w_stop, w_wr_en, w_run;

  // icode only matters for the cmov squash at load time, so it is not kept in the register
  assign w_stop  = (r_stat == S_HLT) || (r_stat == S_ADR) || (r_stat == S_INS);
  assign w_run   = (r_state == RUN);
  assign w_wr_en = w_run && (r_stat == S_AOK);

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == RUN && w_stop) w_state_nxt = HALT;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= RUN;
      r_halt_code <= S_BUB;
    end else begin
      r_state <= w_state_nxt;
      if (w_run && w_stop) r_halt_code <= r_stat;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || (w_run && !w_stall && (w_bubble || !m_valid))) begin
      r_stat <= S_BUB;
      r_dstE <= R_NONE;
      r_valE <= '0;
      r_dstM <= R_NONE;
      r_valM <= '0;
    end else if (w_run && !w_stall) begin
      r_stat <= m_stat;
      r_dstE <= (m_icode == I_CMOV && !m_cnd) ? R_NONE : m_dstE;
      r_valE <= m_valE;
      r_dstM <= m_dstM;
      r_valM <= m_valM;
    end
  end

  assign dstE      = w_wr_en ? r_dstE : R_NONE;
  assign dstM      = w_wr_en ? r_dstM : R_NONE;
  assign valE      = r_valE;
  assign valM      = r_valM;
  assign w_stat    = r_stat;
  assign halted    = !w_run;
  assign halt_code = r_halt_code;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset) r_cnt <= '0;
    else if (w_wr_en && !w_stall && r_cnt != {CNT_W{1'b1}})
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign retire_cnt = r_cnt;
`else
  assign retire_cnt = '0;
`endif

endmodule
